// File: rtl/mfp_ahb_hb_ctrl_pkg.sv
// Shared constants for the heartbeat controller: register map, CTRL/STATUS bit
// positions, capture FSM encoding and the STATUS word packer.
package mfp_ahb_hb_ctrl_pkg;

  localparam logic [1:0] HB_CTRL   = 2'd0;
  localparam logic [1:0] HB_STATUS = 2'd1;
  localparam logic [1:0] HB_DATA   = 2'd2;
  localparam logic [1:0] HB_LAST   = 2'd3;

  localparam int CTRL_EN    = 0;
  localparam int CTRL_IE    = 1;
  localparam int CTRL_FLUSH = 2;
  localparam int STAT_OVF   = 16;
  localparam int STAT_TMO   = 17;

  typedef enum logic [1:0] {
    HB_IDLE     = 2'd0,
    HB_WAIT_RDY = 2'd1,
    HB_ACK      = 2'd2
  } hb_state_e;

  function automatic logic [31:0] hbStatusWord(input logic [4:0] count,
                                               input logic       empty,
                                               input logic       full,
                                               input logic       ovf,
                                               input logic       tmo,
                                               input logic [7:0] tmoCnt);
    hbStatusWord = {tmoCnt, 6'd0, tmo, ovf, 6'd0, full, empty, 3'd0, count};
  endfunction

endpackage

// File: rtl/mfp_ahb_hb_ctrl_if.sv
// AHB-Lite slave-side signal bundle for the heartbeat controller.
interface mfp_ahb_hb_ctrl_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;

  modport master (output HSEL, HADDR, HTRANS, HWRITE, HWDATA, input HRDATA);
  modport slave  (input HSEL, HADDR, HTRANS, HWRITE, HWDATA, output HRDATA);
endinterface

// File: rtl/mfp_ahb_hb_ctrl_sync_fifo.sv
// Single-clock FIFO with synchronous flush; head word is presented combinationally.
module mfp_ahb_hb_ctrl_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  input  logic [WIDTH-1:0]           data_i,
  output logic [WIDTH-1:0]           data_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wrPtr_q, rdPtr_q;
  logic [CNT_W-1:0] count_q;
  logic             doPush_d, doPop_d;

  assign empty_o  = (count_q == '0);
  assign full_o   = (count_q == CNT_W'(DEPTH));
  assign doPop_d  = pop_i && !empty_o;
  assign doPush_d = push_i && (!full_o || doPop_d);

  always_ff @(posedge clk_i) begin
    if (doPush_d && !flush_i) mem_q[wrPtr_q] <= data_i;
  end

  // Flush shares the reset path so a push landing in the same cycle is discarded.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush_d) wrPtr_q <= wrPtr_q + 1'b1;
      if (doPop_d)  rdPtr_q <= rdPtr_q + 1'b1;
      if (doPush_d && !doPop_d)      count_q <= count_q + 1'b1;
      else if (doPop_d && !doPush_d) count_q <= count_q - 1'b1;
    end
  end

  assign data_o  = mem_q[rdPtr_q];
  assign count_o = count_q;
endmodule

// File: rtl/mfp_ahb_hb_ctrl.sv
// AHB-Lite heartbeat controller: peripheral RDY/ACK capture FSM, sample FIFO,
// beat-window timeout tracking and the CPU-visible register file.
module mfp_ahb_hb_ctrl
  import mfp_ahb_hb_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                    HCLK,
  input  logic                    SI_Reset,
  mfp_ahb_hb_ctrl_if.slave        ahb,
  input  logic [31:0]             IO_HEARTBEAT,
  input  logic                    IO_READ_RDY,
  output logic                    IO_READ_ACK,
  output logic                    cpu_cnt_reset,
  input  logic                    time_is_up,
  output logic                    HB_IRQ
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  hb_state_e   state_q;
  logic        dataPhase_q, write_q;
  logic [1:0]  addr_q;
  logic        en_q, ie_q, ovf_q, tmo_q;
  logic [7:0]  tmoCnt_q;
  logic [31:0] last_q;
  logic        ack_q, cntReset_q, irq_q, tiuSeen_q;

  logic [CNT_W-1:0] fifoCount;
  logic             fifoFull, fifoEmpty;
  logic [31:0]      fifoHead;

  logic ctrlWr_d, statusWr_d, dataRd_d, flush_d, enRise_d;
  logic capture_d, push_d, tmoHit_d;
  logic unusedBits;

  assign ctrlWr_d   = dataPhase_q && write_q && (addr_q == HB_CTRL);
  assign statusWr_d = dataPhase_q && write_q && (addr_q == HB_STATUS);
  assign dataRd_d   = dataPhase_q && !write_q && (addr_q == HB_DATA);
  assign flush_d    = ctrlWr_d && ahb.HWDATA[CTRL_FLUSH];
  assign enRise_d   = ctrlWr_d && ahb.HWDATA[CTRL_EN] && !en_q;
  assign capture_d  = (state_q == HB_WAIT_RDY) && en_q && IO_READ_RDY;
  assign push_d     = capture_d && !fifoFull;
  // A held time_is_up level counts once; the edge detector only arms in WAIT_RDY.
  assign tmoHit_d   = (state_q == HB_WAIT_RDY) && time_is_up && !tiuSeen_q;

  assign unusedBits = ^{ahb.HADDR[31:4], ahb.HADDR[1:0], ahb.HTRANS[0], ahb.HWDATA};

  mfp_ahb_hb_ctrl_sync_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (HCLK),
    .rst_i   (SI_Reset),
    .push_i  (push_d),
    .pop_i   (dataRd_d),
    .flush_i (flush_d),
    .data_i  (IO_HEARTBEAT),
    .data_o  (fifoHead),
    .count_o (fifoCount),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty)
  );

  always_ff @(posedge HCLK) begin
    if (SI_Reset) begin
      dataPhase_q <= 1'b0;
      write_q     <= 1'b0;
      addr_q      <= '0;
    end else begin
      dataPhase_q <= ahb.HSEL && ahb.HTRANS[1];
      write_q     <= ahb.HWRITE;
      addr_q      <= ahb.HADDR[3:2];
    end
  end

  // Hardware set of OVF/TMO wins over a same-cycle W1C so no event is lost.
  always_ff @(posedge HCLK) begin
    if (SI_Reset) begin
      en_q       <= 1'b0;
      ie_q       <= 1'b0;
      ovf_q      <= 1'b0;
      tmo_q      <= 1'b0;
      tmoCnt_q   <= '0;
      last_q     <= '0;
      cntReset_q <= 1'b0;
      irq_q      <= 1'b0;
      tiuSeen_q  <= 1'b0;
    end else begin
      if (ctrlWr_d) begin
        en_q <= ahb.HWDATA[CTRL_EN];
        ie_q <= ahb.HWDATA[CTRL_IE];
      end
      if (capture_d) last_q <= IO_HEARTBEAT;
      if (capture_d && fifoFull) ovf_q <= 1'b1;
      else if (statusWr_d && ahb.HWDATA[STAT_OVF]) ovf_q <= 1'b0;
      if (tmoHit_d) begin
        tmo_q <= 1'b1;
        if (tmoCnt_q != 8'hFF) tmoCnt_q <= tmoCnt_q + 8'd1;
      end else if (statusWr_d && ahb.HWDATA[STAT_TMO]) begin
        tmo_q    <= 1'b0;
        tmoCnt_q <= '0;
      end
      tiuSeen_q  <= time_is_up && (state_q == HB_WAIT_RDY);
      cntReset_q <= capture_d || tmoHit_d || enRise_d;
      irq_q      <= ie_q && (!fifoEmpty || ovf_q || tmo_q);
    end
  end

  always_ff @(posedge HCLK) begin
    if (SI_Reset) begin
      state_q <= HB_IDLE;
      ack_q   <= 1'b0;
    end else begin
      case (state_q)
        HB_IDLE: begin
          if (en_q) state_q <= HB_WAIT_RDY;
        end
        HB_WAIT_RDY: begin
          if (!en_q) begin
            state_q <= HB_IDLE;
          end else if (IO_READ_RDY) begin
            state_q <= HB_ACK;
            ack_q   <= 1'b1;
          end
        end
        HB_ACK: begin
          if (!IO_READ_RDY) begin
            ack_q   <= 1'b0;
            state_q <= en_q ? HB_WAIT_RDY : HB_IDLE;
          end
        end
        default: begin
          state_q <= HB_IDLE;
          ack_q   <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    ahb.HRDATA = '0;
    case (addr_q)
      HB_CTRL:   ahb.HRDATA = {30'd0, ie_q, en_q};
      HB_STATUS: ahb.HRDATA = hbStatusWord(5'(fifoCount), fifoEmpty, fifoFull,
                                           ovf_q, tmo_q, tmoCnt_q);
      HB_DATA:   ahb.HRDATA = fifoEmpty ? 32'd0 : fifoHead;
      HB_LAST:   ahb.HRDATA = last_q;
      default:   ahb.HRDATA = '0;
    endcase
  end

  assign IO_READ_ACK   = ack_q;
  assign cpu_cnt_reset = cntReset_q;
  assign HB_IRQ        = irq_q;
endmodule

// File: tb/tb_mfp_ahb_hb_ctrl.sv
// Directed self-checking bench for mfp_ahb_hb_ctrl: handshake, FIFO, timeout,
// EN/reset corner cases, with hand-computed register values.
module tb_mfp_ahb_hb_ctrl;
  logic        HCLK = 1'b0;
  logic        SI_Reset;
  logic [31:0] IO_HEARTBEAT;
  logic        IO_READ_RDY;
  logic        IO_READ_ACK;
  logic        cpu_cnt_reset;
  logic        time_is_up;
  logic        HB_IRQ;

  int checkCount = 0;
  int errorCount = 0;

  localparam logic [1:0] R_CTRL = 2'd0, R_STATUS = 2'd1, R_DATA = 2'd2, R_LAST = 2'd3;

  mfp_ahb_hb_ctrl_if ahbBus();

  mfp_ahb_hb_ctrl #(.FIFO_DEPTH(8)) dut (
    .HCLK          (HCLK),
    .SI_Reset      (SI_Reset),
    .ahb           (ahbBus),
    .IO_HEARTBEAT  (IO_HEARTBEAT),
    .IO_READ_RDY   (IO_READ_RDY),
    .IO_READ_ACK   (IO_READ_ACK),
    .cpu_cnt_reset (cpu_cnt_reset),
    .time_is_up    (time_is_up),
    .HB_IRQ        (HB_IRQ)
  );

  always #5 HCLK = ~HCLK;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic applyStimulus(input logic rdy, input logic [31:0] sample);
    IO_READ_RDY  = rdy;
    IO_HEARTBEAT = sample;
  endtask

  task automatic ahbWrite(input logic [1:0] regSel, input logic [31:0] value);
    ahbBus.HSEL   = 1'b1;
    ahbBus.HTRANS = 2'b10;
    ahbBus.HWRITE = 1'b1;
    ahbBus.HADDR  = {28'd0, regSel, 2'b00};
    tick();
    ahbBus.HSEL   = 1'b0;
    ahbBus.HTRANS = 2'b00;
    ahbBus.HWRITE = 1'b0;
    ahbBus.HWDATA = value;
    tick();
  endtask

  task automatic ahbRead(input logic [1:0] regSel, output logic [31:0] value);
    ahbBus.HSEL   = 1'b1;
    ahbBus.HTRANS = 2'b10;
    ahbBus.HWRITE = 1'b0;
    ahbBus.HADDR  = {28'd0, regSel, 2'b00};
    tick();
    ahbBus.HSEL   = 1'b0;
    ahbBus.HTRANS = 2'b00;
    value = ahbBus.HRDATA;
    tick();
  endtask

  task automatic waitAck(input string tag, input logic level);
    for (int i = 0; i < 20 && IO_READ_ACK !== level; i++) tick();
    checkOutput(tag, {31'd0, IO_READ_ACK}, {31'd0, level});
  endtask

  task automatic doCapture(input string tag, input logic [31:0] sample);
    applyStimulus(1'b1, sample);
    waitAck(tag, 1'b1);
    applyStimulus(1'b0, 32'd0);
    waitAck(tag, 1'b0);
  endtask

  initial begin
    logic [31:0] rd;
    int pulses;

    SI_Reset = 1'b1;
    ahbBus.HSEL = 1'b0; ahbBus.HTRANS = 2'b00; ahbBus.HWRITE = 1'b0;
    ahbBus.HADDR = '0; ahbBus.HWDATA = '0;
    applyStimulus(1'b0, 32'd0);
    time_is_up = 1'b0;
    repeat (3) tick();
    checkOutput("rstAck", {31'd0, IO_READ_ACK}, 32'd0);
    checkOutput("rstCntReset", {31'd0, cpu_cnt_reset}, 32'd0);
    checkOutput("rstIrq", {31'd0, HB_IRQ}, 32'd0);
    SI_Reset = 1'b0;
    tick();
    ahbRead(R_STATUS, rd); checkOutput("rstStatus", rd, 32'h0000_0100);
    ahbRead(R_CTRL, rd);   checkOutput("rstCtrl", rd, 32'h0);
    ahbRead(R_LAST, rd);   checkOutput("rstLast", rd, 32'h0);

    // Single capture and readback
    ahbWrite(R_CTRL, 32'h1);
    checkOutput("enRisePulse", {31'd0, cpu_cnt_reset}, 32'd1);
    applyStimulus(1'b1, 32'h0000_0048);
    tick();
    checkOutput("ackNotEarly", {31'd0, IO_READ_ACK}, 32'd0);
    tick();
    checkOutput("ackRise", {31'd0, IO_READ_ACK}, 32'd1);
    checkOutput("capPulse", {31'd0, cpu_cnt_reset}, 32'd1);
    applyStimulus(1'b0, 32'd0);
    tick();
    checkOutput("ackFall", {31'd0, IO_READ_ACK}, 32'd0);
    ahbRead(R_STATUS, rd); checkOutput("t1Count1", rd, 32'h0000_0001);
    ahbRead(R_DATA, rd);   checkOutput("t1Data", rd, 32'h0000_0048);
    ahbRead(R_STATUS, rd); checkOutput("t1Count0", rd, 32'h0000_0100);

    // Timeouts in WAIT_RDY
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      time_is_up = 1'b1;
      tick();
      pulses += int'(cpu_cnt_reset);
      time_is_up = 1'b0;
      tick();
      pulses += int'(cpu_cnt_reset);
    end
    checkOutput("tmoPulses", pulses, 32'd3);
    ahbWrite(R_CTRL, 32'h3);
    tick();
    checkOutput("tmoIrq", {31'd0, HB_IRQ}, 32'd1);
    ahbRead(R_STATUS, rd); checkOutput("tmoStatus", rd, 32'h0302_0100);
    ahbWrite(R_STATUS, 32'h0002_0000);
    tick();
    checkOutput("tmoIrqClr", {31'd0, HB_IRQ}, 32'd0);
    ahbRead(R_STATUS, rd); checkOutput("tmoCleared", rd, 32'h0000_0100);
    ahbWrite(R_CTRL, 32'h1);

    // Overflow with nine captures
    for (int i = 1; i <= 9; i++) doCapture("ovfCapAck", 32'h100 + 32'(i));
    ahbRead(R_STATUS, rd); checkOutput("ovfStatus", rd, 32'h0001_0208);
    ahbRead(R_LAST, rd);   checkOutput("ovfLast", rd, 32'h0000_0109);
    for (int i = 1; i <= 8; i++) begin
      ahbRead(R_DATA, rd);
      checkOutput("ovfData", rd, 32'h100 + 32'(i));
    end
    ahbRead(R_STATUS, rd); checkOutput("ovfDrained", rd, 32'h0001_0100);
    ahbWrite(R_STATUS, 32'h0001_0000);
    ahbRead(R_STATUS, rd); checkOutput("ovfW1C", rd, 32'h0000_0100);
    ahbRead(R_DATA, rd);   checkOutput("emptyRead", rd, 32'h0);

    // Pop and push in the same cycle
    doCapture("ppCapAck", 32'h0000_00A1);
    ahbBus.HSEL = 1'b1; ahbBus.HTRANS = 2'b10; ahbBus.HWRITE = 1'b0;
    ahbBus.HADDR = {28'd0, R_DATA, 2'b00};
    tick();
    ahbBus.HSEL = 1'b0; ahbBus.HTRANS = 2'b00;
    applyStimulus(1'b1, 32'h0000_00B2);
    checkOutput("ppReadOld", ahbBus.HRDATA, 32'h0000_00A1);
    tick();
    checkOutput("ppAck", {31'd0, IO_READ_ACK}, 32'd1);
    applyStimulus(1'b0, 32'd0);
    waitAck("ppAckFall", 1'b0);
    ahbRead(R_STATUS, rd); checkOutput("ppCount", rd, 32'h0000_0001);
    ahbRead(R_DATA, rd);   checkOutput("ppHead", rd, 32'h0000_00B2);

    // EN cleared mid-handshake
    applyStimulus(1'b1, 32'h0000_00C3);
    waitAck("enOffAck", 1'b1);
    ahbWrite(R_CTRL, 32'h0);
    tick();
    checkOutput("enOffHold", {31'd0, IO_READ_ACK}, 32'd1);
    applyStimulus(1'b0, 32'd0);
    tick();
    checkOutput("enOffDrop", {31'd0, IO_READ_ACK}, 32'd0);
    applyStimulus(1'b1, 32'h0000_00D4);
    repeat (5) tick();
    checkOutput("idleIgnore", {31'd0, IO_READ_ACK}, 32'd0);
    ahbRead(R_LAST, rd);   checkOutput("idleLast", rd, 32'h0000_00C3);
    ahbRead(R_STATUS, rd); checkOutput("idleCount", rd, 32'h0000_0001);
    applyStimulus(1'b0, 32'd0);

    // Reset during ACK
    ahbWrite(R_CTRL, 32'h3);
    tick();
    checkOutput("preRstIrq", {31'd0, HB_IRQ}, 32'd1);
    applyStimulus(1'b1, 32'h0000_00E5);
    waitAck("preRstAck", 1'b1);
    SI_Reset = 1'b1;
    tick();
    checkOutput("rstMidAck", {31'd0, IO_READ_ACK}, 32'd0);
    checkOutput("rstMidIrq", {31'd0, HB_IRQ}, 32'd0);
    SI_Reset = 1'b0;
    applyStimulus(1'b0, 32'd0);
    ahbRead(R_STATUS, rd); checkOutput("rstMidStatus", rd, 32'h0000_0100);
    ahbRead(R_DATA, rd);   checkOutput("rstMidData", rd, 32'h0);

    // Flush empties the FIFO and reads back as 0
    ahbWrite(R_CTRL, 32'h1);
    doCapture("flCapAck", 32'h0000_00F6);
    ahbWrite(R_CTRL, 32'h5);
    ahbRead(R_CTRL, rd);   checkOutput("flCtrl", rd, 32'h0000_0001);
    ahbRead(R_STATUS, rd); checkOutput("flStatus", rd, 32'h0000_0100);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end
endmodule
